video_timing: RTL and testbench
===============================

// Module: video_timing
// PURPOSE
//  Raster timing generator for the 720p60 video path. Runs on pixel_clk and
//  drives signed hpos/vpos, fsync, hsync, vsync and de to all sprite/paddle
//  renderers and the pixel output stage. Coordinates are negative during
//  blanking, and 0..HRES-1 / 0..VRES-1 inside the active area.
// PARAMETERS
//  HRES     1280  active pixels per line
//  VRES     720   active lines per frame
//  HFP      110   horizontal front porch (pixels)
//  HSW      40    hsync width (pixels)
//  HBP      220   horizontal back porch (pixels)
//  VFP      5     vertical front porch (lines)
//  VSW      5     vsync width (lines)
//  VBP      20    vertical back porch (lines)
//  HS_POL   1     hsync active level
//  VS_POL   1     vsync active level
// PORTS
//  pixel_clk  in   1   pixel clock; the only clock
//  rst        in   1   synchronous, active-high reset
//  hpos       out  12  signed x coordinate, H_START..HRES-1
//  vpos       out  12  signed y coordinate, V_START..VRES-1
//  fsync      out  1   one-cycle pulse at the first pixel of each frame
//  hsync      out  1   horizontal sync, level HS_POL while active
//  vsync      out  1   vertical sync, level VS_POL while active
//  de         out  1   data enable: high when hpos>=0 and vpos>=0
// BEHAVIOUR
//  - Derived constants:
//    - H_START = -(HFP+HSW+HBP) = -370; V_START = -(VFP+VSW+VBP) = -30.
//    - Totals: 1650 pixels/line, 750 lines/frame.
//  - Line order: front porch, sync, back porch, active.
//  - hsync active for hpos in [H_START+HFP, H_START+HFP+HSW-1].
//  - vsync active for vpos in [V_START+VFP, V_START+VFP+VSW-1]. It changes
//    only on the cycle where hpos wraps to H_START.
//  - Counting: hpos increments by 1 every clock.
//    - At hpos==HRES-1 the next hpos is H_START and vpos increments.
//    - At vpos==VRES-1 with a line wrap, the next vpos is V_START.
//  - All outputs are registered and mutually consistent in the same cycle.
//    Downstream sees hpos/vpos/de/syncs for one pixel on the same edge.
//  - fsync=1 exactly in the cycle where hpos==H_START and vpos==V_START.
//  - While rst is high, outputs are held at:
//    - hpos=HRES-1, vpos=VRES-1
//    - fsync=0, de=0
//    - hsync=!HS_POL, vsync=!VS_POL
//  - First clock after rst falls: hpos=H_START, vpos=V_START, fsync=1.
//    A new frame starts cleanly; no partial-frame pulse.
//  - Reset mid-frame: takes effect on the next edge and overrides counting.
//  - Arithmetic is 12-bit two's complement.
//    - Elaboration check: HRES-1 <= 2047, VRES-1 <= 2047,
//      H_START >= -2048, V_START >= -2048.
//    - Every porch/sync parameter must be >= 1.
// STRUCTURE
//  - video_pkg holds:
//    - 720p default timing constants
//    - POS_W=12
//    - typedef signed [POS_W-1:0] pos_t, shared with paddle/sprite blocks
//  - Sub-module timing_axis is instantiated twice (horizontal, vertical):
//    - parameters: active length, FP, SW, BP, sync polarity
//    - inputs: step enable
//    - outputs: pos, sync, wrap, active
//    - horizontal instance: step=1; vertical instance: step = horizontal wrap.
// TESTING
//  - Reset release: hold rst 4 clocks, drop it. Next cycle must show
//    hpos=-370, vpos=-30, fsync=1, de=0.
//  - Line timing: hpos sequence -370..1279, 1650 clocks, then -370 again.
//    hsync high exactly for hpos -260..-221 (40 clocks).
//  - Frame timing: consecutive fsync pulses exactly 1,237,500 clocks apart.
//    de high for exactly 921,600 clocks per frame.
//  - vsync: high for vpos -25..-21 only, 8,250 clocks total.
//    Edges coincide with hpos==-370.
//  - Mid-frame reset: assert rst at vpos=300, hpos=500 for 1 clock.
//    Next cycle shows reset values; the cycle after shows fsync=1 at (-370,-30).
//  - Polarity: HS_POL=0, VS_POL=0. Syncs idle high, pulse low at the same
//    positions. Reset value is high.

Source files
------------

// File: rtl/video_pkg.sv
// Shared raster-timing types and the default 720p60 timing constants.
package video_pkg;

    localparam int POS_W = 12;

    // Signed screen coordinate, negative during blanking.
    typedef logic signed [POS_W-1:0] pos_t;

    localparam int HRES_720P = 1280;
    localparam int VRES_720P = 720;
    localparam int HFP_720P  = 110;
    localparam int HSW_720P  = 40;
    localparam int HBP_720P  = 220;
    localparam int VFP_720P  = 5;
    localparam int VSW_720P  = 5;
    localparam int VBP_720P  = 20;

    localparam int POS_MAX = (2 ** (POS_W - 1)) - 1;
    localparam int POS_MIN = -(2 ** (POS_W - 1));

    // First coordinate of a line/frame: the blanking interval sits before zero.
    function automatic int axis_start(input int fp, input int sw, input int bp);
        return -(fp + sw + bp);
    endfunction

endpackage

// File: rtl/timing_axis.sv
// One raster axis: a signed position counter running START..ACTIVE-1 with a
// sync window inside the blanking region (front porch, sync, back porch).
module timing_axis
    import video_pkg::*;
#(
    parameter int   ACTIVE   = HRES_720P,
    parameter int   FP       = HFP_720P,
    parameter int   SW       = HSW_720P,
    parameter int   BP       = HBP_720P,
    parameter logic SYNC_POL = 1'b1
)(
    input  logic clk,
    input  logic rst,
    input  logic i_step,
    output pos_t o_pos,
    output logic o_sync,
    output logic o_wrap,
    output logic o_active_nxt
);

    localparam int   START_I   = axis_start(FP, SW, BP);
    localparam pos_t P_START   = pos_t'(START_I);
    localparam pos_t P_LAST    = pos_t'(ACTIVE - 1);
    localparam pos_t P_SYNC_LO = pos_t'(START_I + FP);
    localparam pos_t P_SYNC_HI = pos_t'(START_I + FP + SW - 1);
    localparam pos_t P_ZERO    = pos_t'(0);

    if (ACTIVE - 1 > POS_MAX || ACTIVE < 1) begin : g_bad_active
        $error("timing_axis: ACTIVE out of range for POS_W");
    end
    if (START_I < POS_MIN) begin : g_bad_start
        $error("timing_axis: blanking too long for POS_W");
    end
    if (FP < 1 || SW < 1 || BP < 1) begin : g_bad_porch
        $error("timing_axis: porch and sync widths must be at least 1");
    end

    pos_t r_pos;
    logic r_sync;
    pos_t w_pos_nxt;
    logic w_last;
    logic w_sync_nxt;

    // Next position and the flags derived from it, so everything downstream
    // can be registered on the same edge as the counter itself.
    always_comb begin
        w_last     = (r_pos == P_LAST);
        w_pos_nxt  = r_pos;
        if (i_step) begin
            w_pos_nxt = w_last ? P_START : r_pos + pos_t'(1);
        end
        w_sync_nxt = ((w_pos_nxt >= P_SYNC_LO) && (w_pos_nxt <= P_SYNC_HI)) ? SYNC_POL : !SYNC_POL;
    end

    // Reset parks the counter on the last active position so the first
    // step out of reset lands exactly on START.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pos  <= P_LAST;
            r_sync <= !SYNC_POL;
        end else begin
            r_pos  <= w_pos_nxt;
            r_sync <= w_sync_nxt;
        end
    end

    assign o_pos        = r_pos;
    assign o_sync       = r_sync;
    assign o_wrap       = i_step && w_last;
    assign o_active_nxt = (w_pos_nxt >= P_ZERO);

endmodule

// File: rtl/video_timing.sv
// Raster timing generator: horizontal axis steps every pixel, vertical axis
// steps on each horizontal wrap. All outputs come straight from flops.
module video_timing
    import video_pkg::*;
#(
    parameter int   HRES   = HRES_720P,
    parameter int   VRES   = VRES_720P,
    parameter int   HFP    = HFP_720P,
    parameter int   HSW    = HSW_720P,
    parameter int   HBP    = HBP_720P,
    parameter int   VFP    = VFP_720P,
    parameter int   VSW    = VSW_720P,
    parameter int   VBP    = VBP_720P,
    parameter logic HS_POL = 1'b1,
    parameter logic VS_POL = 1'b1
)(
    input  logic                    pixel_clk,
    input  logic                    rst,
    output logic signed [POS_W-1:0] hpos,
    output logic signed [POS_W-1:0] vpos,
    output logic                    fsync,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    de
);

    pos_t w_hpos;
    pos_t w_vpos;
    logic w_hsync;
    logic w_vsync;
    logic w_h_wrap;
    logic w_v_wrap;
    logic w_h_active_nxt;
    logic w_v_active_nxt;
    logic r_fsync;
    logic r_de;

    timing_axis #(
        .ACTIVE   (HRES),
        .FP       (HFP),
        .SW       (HSW),
        .BP       (HBP),
        .SYNC_POL (HS_POL)
    ) u_h_axis (
        .clk          (pixel_clk),
        .rst          (rst),
        .i_step       (1'b1),
        .o_pos        (w_hpos),
        .o_sync       (w_hsync),
        .o_wrap       (w_h_wrap),
        .o_active_nxt (w_h_active_nxt)
    );

    timing_axis #(
        .ACTIVE   (VRES),
        .FP       (VFP),
        .SW       (VSW),
        .BP       (VBP),
        .SYNC_POL (VS_POL)
    ) u_v_axis (
        .clk          (pixel_clk),
        .rst          (rst),
        .i_step       (w_h_wrap),
        .o_pos        (w_vpos),
        .o_sync       (w_vsync),
        .o_wrap       (w_v_wrap),
        .o_active_nxt (w_v_active_nxt)
    );

    // Frame pulse and data enable registered from the axes' next-state flags
    // so they line up with the coordinates they describe. A vertical wrap
    // means the next pixel is (H_START, V_START), including the reset exit.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_fsync <= 1'b0;
            r_de    <= 1'b0;
        end else begin
            r_fsync <= w_v_wrap;
            r_de    <= w_h_active_nxt & w_v_active_nxt;
        end
    end

    assign hpos  = w_hpos;
    assign vpos  = w_vpos;
    assign hsync = w_hsync;
    assign vsync = w_vsync;
    assign fsync = r_fsync;
    assign de    = r_de;

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: a 720p instance and a small inverted-polarity
// instance, both compared every cycle against an arithmetic raster model.
module tb_video_timing;
    import video_pkg::*;

    localparam int B_HRES = 16, B_VRES = 8;
    localparam int B_HFP = 2, B_HSW = 3, B_HBP = 4;
    localparam int B_VFP = 1, B_VSW = 2, B_VBP = 3;
    localparam int A_TOT = 1650 * 750;
    localparam int B_TOT = (B_HRES + B_HFP + B_HSW + B_HBP) * (B_VRES + B_VFP + B_VSW + B_VBP);

    typedef struct {
        int hp;
        int vp;
        bit fs;
        bit hs;
        bit vs;
        bit de;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    logic signed [11:0] hpos_a, vpos_a, hpos_b, vpos_b;
    logic fsync_a, hsync_a, vsync_a, de_a;
    logic fsync_b, hsync_b, vsync_b, de_b;

    int n_checks = 0;
    int n_err    = 0;
    int t_a = 0, t_b = 0;
    bit inr_a = 1'b1, inr_b = 1'b1;

    video_timing u_dut_a (
        .pixel_clk (clk),
        .rst       (rst_a),
        .hpos      (hpos_a),
        .vpos      (vpos_a),
        .fsync     (fsync_a),
        .hsync     (hsync_a),
        .vsync     (vsync_a),
        .de        (de_a)
    );

    video_timing #(
        .HRES (B_HRES), .VRES (B_VRES),
        .HFP (B_HFP), .HSW (B_HSW), .HBP (B_HBP),
        .VFP (B_VFP), .VSW (B_VSW), .VBP (B_VBP),
        .HS_POL (1'b0), .VS_POL (1'b0)
    ) u_dut_b (
        .pixel_clk (clk),
        .rst       (rst_b),
        .hpos      (hpos_b),
        .vpos      (vpos_b),
        .fsync     (fsync_b),
        .hsync     (hsync_b),
        .vsync     (vsync_b),
        .de        (de_b)
    );

    // Expected outputs from the pixel index t since the frame start.
    function automatic exp_t ref_out(input int t, input bit in_rst,
                                     input int hres, input int vres,
                                     input int hfp, input int hsw, input int hbp,
                                     input int vfp, input int vsw, input int vbp,
                                     input bit hpol, input bit vpol);
        exp_t e;
        int htot, x, y;
        htot = hres + hfp + hsw + hbp;
        if (in_rst) begin
            e.hp = hres - 1;
            e.vp = vres - 1;
            e.fs = 1'b0;
            e.de = 1'b0;
            e.hs = !hpol;
            e.vs = !vpol;
        end else begin
            x = t % htot;
            y = t / htot;
            e.hp = x - (hfp + hsw + hbp);
            e.vp = y - (vfp + vsw + vbp);
            e.hs = (x >= hfp && x < hfp + hsw) ? hpol : !hpol;
            e.vs = (y >= vfp && y < vfp + vsw) ? vpol : !vpol;
            e.de = (e.hp >= 0) && (e.vp >= 0);
            e.fs = (t == 0);
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_set(input string p, input exp_t e,
                             input logic signed [11:0] hp, input logic signed [11:0] vp,
                             input logic fs, input logic hs, input logic vs, input logic de);
        chk({p, "_hpos"},  hp, e.hp);
        chk({p, "_vpos"},  vp, e.vp);
        chk({p, "_fsync"}, {31'd0, fs}, {31'd0, e.fs});
        chk({p, "_hsync"}, {31'd0, hs}, {31'd0, e.hs});
        chk({p, "_vsync"}, {31'd0, vs}, {31'd0, e.vs});
        chk({p, "_de"},    {31'd0, de}, {31'd0, e.de});
    endtask

    // One clock: advance both models on the edge, compare on the falling edge.
    task automatic step();
        exp_t ea, eb;
        @(posedge clk);
        if (rst_a) inr_a = 1'b1;
        else begin
            t_a   = inr_a ? 0 : (t_a + 1) % A_TOT;
            inr_a = 1'b0;
        end
        if (rst_b) inr_b = 1'b1;
        else begin
            t_b   = inr_b ? 0 : (t_b + 1) % B_TOT;
            inr_b = 1'b0;
        end
        @(negedge clk);
        ea = ref_out(t_a, inr_a, 1280, 720, 110, 40, 220, 5, 5, 20, 1'b1, 1'b1);
        eb = ref_out(t_b, inr_b, B_HRES, B_VRES, B_HFP, B_HSW, B_HBP, B_VFP, B_VSW, B_VBP, 1'b0, 1'b0);
        check_set("a", ea, hpos_a, vpos_a, fsync_a, hsync_a, vsync_a, de_a);
        check_set("b", eb, hpos_b, vpos_b, fsync_b, hsync_b, vsync_b, de_b);
    endtask

    task automatic measure_frame(output int len, output int de_cnt);
        len = 0;
        de_cnt = 0;
        do begin
            if (de_b === 1'b1) de_cnt++;
            step();
            len++;
        end while (fsync_b !== 1'b1 && len < 1000);
    endtask

    initial begin
        int hs_cnt, vs_cnt, len, de_cnt, w;
        logic prev_vs;

        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (4) step();
        chk("a_rst_hpos", hpos_a, 1279);
        chk("a_rst_vpos", vpos_a, 719);
        chk("b_rst_hsync_idle_high", {31'd0, hsync_b}, 1);

        // 720p reset release and first 12 lines.
        rst_a = 1'b0;
        step();
        chk("a_release_hpos", hpos_a, -370);
        chk("a_release_vpos", vpos_a, -30);
        chk("a_release_fsync", {31'd0, fsync_a}, 1);
        chk("a_release_de", {31'd0, de_a}, 0);
        hs_cnt  = (hsync_a === 1'b1) ? 1 : 0;
        vs_cnt  = (vsync_a === 1'b1) ? 1 : 0;
        prev_vs = vsync_a;
        for (int k = 1; k < 12 * 1650; k++) begin
            step();
            if (k < 1650 && hsync_a === 1'b1) hs_cnt++;
            if (vsync_a === 1'b1) vs_cnt++;
            if (vsync_a !== prev_vs) chk("a_vsync_edge_hpos", hpos_a, -370);
            prev_vs = vsync_a;
            if (k == 1650) begin
                chk("a_line_wrap_hpos", hpos_a, -370);
                chk("a_line_wrap_vpos", vpos_a, -29);
            end
        end
        chk("a_hsync_clocks_per_line", hs_cnt, 40);
        chk("a_vsync_clocks", vs_cnt, 8250);

        // Small inverted-polarity instance: whole frames.
        rst_b = 1'b0;
        step();
        chk("b_release_fsync", {31'd0, fsync_b}, 1);
        chk("b_release_hpos", hpos_b, -9);
        for (int f = 0; f < 2; f++) begin
            measure_frame(len, de_cnt);
            chk("b_frame_len", len, B_TOT);
            chk("b_de_per_frame", de_cnt, B_HRES * B_VRES);
        end

        // Mid-frame reset in the active area.
        w = 0;
        while (!(hpos_b === 12'sd8 && vpos_b === 12'sd4) && w < 400) begin
            step();
            w++;
        end
        chk("b_midframe_reached", {31'd0, (w < 400)}, 1);
        rst_b = 1'b1;
        step();
        chk("b_mid_rst_hpos", hpos_b, B_HRES - 1);
        chk("b_mid_rst_vsync", {31'd0, vsync_b}, 1);
        rst_b = 1'b0;
        step();
        chk("b_mid_restart_fsync", {31'd0, fsync_b}, 1);
        chk("b_mid_restart_vpos", vpos_b, -6);

        // Random reset pulses on the small instance while the 720p one runs on.
        for (int k = 0; k < 1500; k++) begin
            if (rst_b) rst_b = ($urandom_range(0, 1) == 0) ? 1'b0 : 1'b1;
            else       rst_b = ($urandom_range(0, 149) == 0);
            step();
        end
        rst_b = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
